// File: rtl/global_pkg.sv
// Shared track-word layout, decode helper, default histogrammer constants and FSM state type.
// Pure declarations: no latency, no flow control.
package global_pkg;

   localparam int c_TRACKS_IN_SET    = 2;
   localparam int c_SETS_IN_EVENT    = 4;
   localparam int c_HIST_BINS        = 16;
   localparam int c_HIST_BIN_WIDTH   = 8;
   localparam int c_PT_MAX           = 63;
   localparam int c_HIST_Z0_SHIFT    = 3;
   localparam int c_HIST_WEIGHT_MODE = 0;

   localparam int c_PT_WIDTH = 16;
   localparam int c_Z0_WIDTH = 12;

   typedef struct packed {
      logic [c_PT_WIDTH-1:0] pt;
      logic [c_Z0_WIDTH-1:0] z0;
      logic [11:0]           phi;
      logic [15:0]           eta;
      logic [7:0]            quality;
   } t_track_word_struct;

   localparam int c_TRACK_WORD_WIDTH = $bits(t_track_word_struct);

   function automatic t_track_word_struct tw2tw_struct(input logic [c_TRACK_WORD_WIDTH-1:0] tw);
      return t_track_word_struct'(tw);
   endfunction

   typedef enum logic [1:0] {
      ST_ACC,
      ST_DRAIN,
      ST_WAIT,
      ST_MERGE
   } t_hist_state;

endpackage

// File: rtl/vertex_hist_lane.sv
// One track lane: decode z0 bin and weight, then saturating-add into a private histogram.
// Two-stage pipeline (decode register, accumulator update); no backpressure, clr wins over updates.
module vertex_hist_lane
   import global_pkg::*;
#(
   parameter int N_BINS      = c_HIST_BINS,
   parameter int BIN_W       = c_HIST_BIN_WIDTH,
   parameter int Z0_SHIFT    = c_HIST_Z0_SHIFT,
   parameter int PT_MAX      = c_PT_MAX,
   parameter int WEIGHT_MODE = c_HIST_WEIGHT_MODE
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clr,
   input  logic                          acc_en,
   input  logic                          trk_vld,
   input  logic [c_TRACK_WORD_WIDTH-1:0] trk_word,
   output logic [N_BINS*BIN_W-1:0]       acc_out,
   output logic                          cnt_out,
   output logic                          sat_out
);

   localparam int IDX_W = $clog2(N_BINS);
   localparam int SUM_W = BIN_W + c_PT_WIDTH + 1;
   localparam logic [SUM_W-1:0] ACC_MAX = SUM_W'({BIN_W{1'b1}});

   t_track_word_struct    tw_dec;
   logic signed [31:0]    bin_s;
   logic [c_PT_WIDTH-1:0] pt_half;
   logic [SUM_W-1:0]      sum;

   logic                  s1_vld_q, s1_vld_d;
   logic [IDX_W-1:0]      s1_bin_q, s1_bin_d;
   logic [c_PT_WIDTH-1:0] s1_wt_q, s1_wt_d;
   logic [BIN_W-1:0]      acc_q [N_BINS];
   logic [BIN_W-1:0]      acc_d [N_BINS];
   logic                  sat_q, sat_d;

   assign tw_dec = tw2tw_struct(trk_word);

   logic unused_fields;
   assign unused_fields = ^{tw_dec.phi, tw_dec.eta, tw_dec.quality, tw_dec.pt[0],
                            tw_dec.z0[Z0_SHIFT-1:0]};

   always_comb begin
      bin_s    = 32'($signed(tw_dec.z0[c_Z0_WIDTH-1:Z0_SHIFT])) + (N_BINS / 2);
      pt_half  = tw_dec.pt >> 1;
      s1_vld_d = acc_en && trk_vld && (bin_s >= 0) && (bin_s < N_BINS);
      s1_bin_d = bin_s[IDX_W-1:0];
      if (WEIGHT_MODE != 0) begin
         s1_wt_d = c_PT_WIDTH'(1);
      end else if (pt_half > c_PT_WIDTH'(PT_MAX)) begin
         s1_wt_d = c_PT_WIDTH'(PT_MAX);
      end else begin
         s1_wt_d = pt_half;
      end

      acc_d = acc_q;
      sat_d = sat_q;
      sum   = SUM_W'(acc_q[s1_bin_q]) + SUM_W'(s1_wt_q);
      if (s1_vld_q) begin
         if (sum > ACC_MAX) begin
            acc_d[s1_bin_q] = '1;
            sat_d           = 1'b1;
         end else begin
            acc_d[s1_bin_q] = sum[BIN_W-1:0];
         end
      end

      if (clr) begin
         for (int b = 0; b < N_BINS; b++) acc_d[b] = '0;
         sat_d    = 1'b0;
         s1_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q <= 1'b0;
         s1_bin_q <= '0;
         s1_wt_q  <= '0;
         sat_q    <= 1'b0;
         for (int b = 0; b < N_BINS; b++) acc_q[b] <= '0;
      end else begin
         s1_vld_q <= s1_vld_d;
         s1_bin_q <= s1_bin_d;
         s1_wt_q  <= s1_wt_d;
         sat_q    <= sat_d;
         acc_q    <= acc_d;
      end
   end

   for (genvar b = 0; b < N_BINS; b++) begin : g_out
      assign acc_out[b*BIN_W +: BIN_W] = acc_q[b];
   end

   assign cnt_out = s1_vld_q;
   assign sat_out = sat_q;

endmodule

// File: rtl/vertex_hist_accum.sv
// Per-event z0 histogrammer: lane accumulators merged into a double-buffered flat histogram.
// Last set to valid output is 4 cycles; input stalls while a finished event waits on rdy_in.
module vertex_hist_accum
   import global_pkg::*;
#(
   parameter int N_TRK       = c_TRACKS_IN_SET,
   parameter int N_SETS      = c_SETS_IN_EVENT,
   parameter int N_BINS      = c_HIST_BINS,
   parameter int BIN_W       = c_HIST_BIN_WIDTH,
   parameter int Z0_SHIFT    = c_HIST_Z0_SHIFT,
   parameter int PT_MAX      = c_PT_MAX,
   parameter int WEIGHT_MODE = c_HIST_WEIGHT_MODE
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [N_TRK*c_TRACK_WORD_WIDTH-1:0] track_set_in,
   input  logic [N_TRK-1:0]                    trk_vld_in,
   input  logic                                vld_in,
   output logic                                rdy_out,
   output logic [N_BINS*BIN_W-1:0]             hist_out,
   output logic                                vld_out,
   input  logic                                rdy_in,
   output logic [15:0]                         trk_cnt_out,
   output logic                                sat_out,
   output logic [$clog2(N_SETS+1)-1:0]         set_cnt_out
);

   localparam int SC_W = $clog2(N_SETS+1);
   localparam int MW   = BIN_W + $clog2(N_TRK);
   localparam logic [MW-1:0] MERGE_MAX = MW'({BIN_W{1'b1}});

   t_hist_state               state_q, state_d;
   logic                      drain_q, drain_d;
   logic [SC_W-1:0]           set_cnt_q, set_cnt_d;
   logic [15:0]               trk_evt_q, trk_evt_d;
   logic [N_BINS*BIN_W-1:0]   hist_q, hist_d;
   logic                      vld_q, vld_d;
   logic [15:0]               trk_cnt_q, trk_cnt_d;
   logic                      sat_q, sat_d;

   logic                      accept, lane_clr, slot_free, merge_sat;
   logic [N_BINS*BIN_W-1:0]   lane_acc [N_TRK];
   logic [N_TRK-1:0]          lane_cnt, lane_sat;
   logic [N_BINS*BIN_W-1:0]   merge_hist;
   logic [MW-1:0]             msum;
   logic [16:0]               trk_sum;

   assign rdy_out  = (state_q == ST_ACC) && !rst;
   assign accept   = vld_in && rdy_out;
   assign lane_clr = (state_q == ST_MERGE);

   for (genvar l = 0; l < N_TRK; l++) begin : g_lane
      vertex_hist_lane #(
         .N_BINS      (N_BINS),
         .BIN_W       (BIN_W),
         .Z0_SHIFT    (Z0_SHIFT),
         .PT_MAX      (PT_MAX),
         .WEIGHT_MODE (WEIGHT_MODE)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .clr      (lane_clr),
         .acc_en   (accept),
         .trk_vld  (trk_vld_in[l]),
         .trk_word (track_set_in[l*c_TRACK_WORD_WIDTH +: c_TRACK_WORD_WIDTH]),
         .acc_out  (lane_acc[l]),
         .cnt_out  (lane_cnt[l]),
         .sat_out  (lane_sat[l])
      );
   end

   // Bin-wise sum across lanes in widened precision, clamped back to BIN_W.
   always_comb begin
      merge_hist = '0;
      merge_sat  = 1'b0;
      msum       = '0;
      for (int b = 0; b < N_BINS; b++) begin
         msum = '0;
         for (int l = 0; l < N_TRK; l++) msum = msum + MW'(lane_acc[l][b*BIN_W +: BIN_W]);
         if (msum > MERGE_MAX) begin
            merge_hist[b*BIN_W +: BIN_W] = '1;
            merge_sat                    = 1'b1;
         end else begin
            merge_hist[b*BIN_W +: BIN_W] = msum[BIN_W-1:0];
         end
      end
   end

   always_comb begin
      trk_sum = {1'b0, trk_evt_q};
      for (int l = 0; l < N_TRK; l++) trk_sum = trk_sum + 17'(lane_cnt[l]);
   end

   always_comb begin
      state_d   = state_q;
      drain_d   = drain_q;
      set_cnt_d = set_cnt_q;
      trk_evt_d = trk_sum[16] ? 16'hFFFF : trk_sum[15:0];
      hist_d    = hist_q;
      vld_d     = vld_q;
      trk_cnt_d = trk_cnt_q;
      sat_d     = sat_q;
      slot_free = !vld_q || rdy_in;

      if (vld_q && rdy_in) vld_d = 1'b0;

      case (state_q)
         ST_ACC: begin
            if (accept) begin
               set_cnt_d = set_cnt_q + 1'b1;
               if (set_cnt_q == SC_W'(N_SETS-1)) begin
                  state_d = ST_DRAIN;
                  drain_d = 1'b0;
               end
            end
         end
         ST_DRAIN: begin
            if (!drain_q) drain_d = 1'b1;
            else          state_d = slot_free ? ST_MERGE : ST_WAIT;
         end
         ST_WAIT: begin
            if (slot_free) state_d = ST_MERGE;
         end
         ST_MERGE: begin
            hist_d    = merge_hist;
            trk_cnt_d = trk_evt_q;
            sat_d     = (|lane_sat) || merge_sat;
            vld_d     = 1'b1;
            set_cnt_d = '0;
            trk_evt_d = '0;
            state_d   = ST_ACC;
         end
         default: state_d = ST_ACC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_ACC;
         drain_q   <= 1'b0;
         set_cnt_q <= '0;
         trk_evt_q <= '0;
         hist_q    <= '0;
         vld_q     <= 1'b0;
         trk_cnt_q <= '0;
         sat_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         drain_q   <= drain_d;
         set_cnt_q <= set_cnt_d;
         trk_evt_q <= trk_evt_d;
         hist_q    <= hist_d;
         vld_q     <= vld_d;
         trk_cnt_q <= trk_cnt_d;
         sat_q     <= sat_d;
      end
   end

   assign hist_out    = hist_q;
   assign vld_out     = vld_q;
   assign trk_cnt_out = trk_cnt_q;
   assign sat_out     = sat_q;
   assign set_cnt_out = set_cnt_q;

endmodule

// File: tb/tb_vertex_hist_accum.sv
// Directed and randomized bench for vertex_hist_accum against an event-level histogram model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_vertex_hist_accum;

   localparam int NT = 2;
   localparam int NS = 4;
   localparam int NB = 16;
   localparam int BW = 8;
   localparam int WW = 64;

   logic               clk = 1'b0;
   logic               rst;
   logic [NT*WW-1:0]   track_set_in;
   logic [NT-1:0]      trk_vld_in;
   logic               vld_in;
   logic               rdy_out;
   logic [NB*BW-1:0]   hist_out;
   logic               vld_out;
   logic               rdy_in;
   logic [15:0]        trk_cnt_out;
   logic               sat_out;
   logic [2:0]         set_cnt_out;

   always #5 clk = ~clk;

   vertex_hist_accum #(
      .N_TRK(NT), .N_SETS(NS), .N_BINS(NB), .BIN_W(BW),
      .Z0_SHIFT(3), .PT_MAX(63), .WEIGHT_MODE(0)
   ) dut (
      .clk(clk), .rst(rst), .track_set_in(track_set_in), .trk_vld_in(trk_vld_in),
      .vld_in(vld_in), .rdy_out(rdy_out), .hist_out(hist_out), .vld_out(vld_out),
      .rdy_in(rdy_in), .trk_cnt_out(trk_cnt_out), .sat_out(sat_out),
      .set_cnt_out(set_cnt_out)
   );

   int vectors = 0;
   int miscompares = 0;

   int lane_acc [NT][NB];
   int ev_cnt;
   bit ev_sat;
   int ev_sets;
   logic [127:0] exp_hist_q [$];
   int           exp_cnt_q  [$];
   bit           exp_sat_q  [$];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mk_word(input int pt, input int z0);
      logic [15:0] p;
      logic [11:0] z;
      p = pt[15:0];
      z = z0[11:0];
      return {p, z, $urandom, 4'($urandom)};
   endfunction

   task automatic model_clear();
      for (int l = 0; l < NT; l++)
         for (int b = 0; b < NB; b++) lane_acc[l][b] = 0;
      ev_cnt  = 0;
      ev_sat  = 0;
      ev_sets = 0;
   endtask

   // Event-level reference: floor(z0/8)+8 bin, min(pT/2,63) weight, lane and merge clamps at 255.
   task automatic model_accept(input logic [127:0] words, input logic [1:0] tv);
      logic [63:0]        w;
      logic signed [11:0] zs;
      int zi, pt, b, wt, s;
      logic [127:0] h;
      for (int l = 0; l < NT; l++) begin
         w  = words[l*64 +: 64];
         pt = int'(w[63:48]);
         zs = w[47:36];
         zi = zs;
         b  = ((zi < 0) ? -((-zi + 7) / 8) : zi / 8) + NB / 2;
         wt = (pt / 2 > 63) ? 63 : pt / 2;
         if (tv[l] && b >= 0 && b < NB) begin
            ev_cnt++;
            s = lane_acc[l][b] + wt;
            if (s > 255) begin s = 255; ev_sat = 1; end
            lane_acc[l][b] = s;
         end
      end
      ev_sets++;
      if (ev_sets == NS) begin
         h = '0;
         for (int bb = 0; bb < NB; bb++) begin
            s = 0;
            for (int l = 0; l < NT; l++) s += lane_acc[l][bb];
            if (s > 255) begin s = 255; ev_sat = 1; end
            h[bb*8 +: 8] = s[7:0];
         end
         exp_hist_q.push_back(h);
         exp_cnt_q.push_back(ev_cnt);
         exp_sat_q.push_back(ev_sat);
         model_clear();
      end
   endtask

   task automatic drive_set(input logic [127:0] words, input logic [1:0] tv);
      int n = 0;
      track_set_in = words;
      trk_vld_in   = tv;
      vld_in       = 1'b1;
      while (rdy_out !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("rdy_wait", rdy_out, 1);
      @(posedge clk);
      model_accept(words, tv);
      @(negedge clk);
      vld_in     = 1'b0;
      trk_vld_in = '0;
   endtask

   task automatic rand_set(output logic [127:0] words, output logic [1:0] tv);
      words = {mk_word($urandom_range(0, 300), int'($urandom_range(0, 200)) - 100),
               mk_word($urandom_range(0, 300), int'($urandom_range(0, 200)) - 100)};
      tv    = 2'($urandom);
   endtask

   task automatic latency_check();
      for (int k = 1; k <= 3; k++) begin
         check("drain_rdy", rdy_out, 0);
         check("drain_vld", vld_out, 0);
         @(negedge clk);
      end
      check("lat_vld", vld_out, 1);
      check("lat_rdy", rdy_out, 1);
   endtask

   task automatic check_out(input string tag);
      int n = 0;
      while (vld_out !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_vld"}, vld_out, 1);
      check({tag, "_hist"}, hist_out, exp_hist_q[0]);
      check({tag, "_cnt"}, trk_cnt_out, 128'(exp_cnt_q[0]));
      check({tag, "_sat"}, sat_out, exp_sat_q[0]);
   endtask

   task automatic consume();
      rdy_in = 1'b1;
      @(negedge clk);
      rdy_in = 1'b0;
      void'(exp_hist_q.pop_front());
      void'(exp_cnt_q.pop_front());
      void'(exp_sat_q.pop_front());
      check("vld_drop", vld_out, 0);
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      vld_in = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_rdy", rdy_out, 0);
      check("rst_vld", vld_out, 0);
      check("rst_hist", hist_out, 0);
      check("rst_cnt", trk_cnt_out, 0);
      check("rst_sat", sat_out, 0);
      check("rst_setcnt", set_cnt_out, 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_rdy", rdy_out, 1);
      model_clear();
      exp_hist_q.delete();
      exp_cnt_q.delete();
      exp_sat_q.delete();
   endtask

   initial begin
      logic [127:0] words;
      logic [1:0]   tv;
      logic [127:0] s1_hist;
      s1_hist      = 128'h50 << 64;
      rst          = 1'b1;
      vld_in       = 1'b0;
      rdy_in       = 1'b0;
      track_set_in = '0;
      trk_vld_in   = '0;
      model_clear();
      @(negedge clk);
      do_reset();

      // basic event: bin 8 collects 8 tracks of weight 10
      for (int s = 0; s < NS; s++) drive_set({mk_word(20, 0), mk_word(20, 0)}, 2'b11);
      latency_check();
      check_out("s1");
      check("s1_bin8", hist_out, s1_hist);
      check("s1_cnt8", trk_cnt_out, 8);
      consume();

      // merge clamp: 2 lanes x 4 x 63 = 504
      for (int s = 0; s < NS; s++) drive_set({mk_word(254, 0), mk_word(254, 0)}, 2'b11);
      latency_check();
      check_out("s2");
      check("s2_sat", sat_out, 1);
      check("s2_bin8", hist_out, 128'hFF << 64);
      consume();

      // out-of-range bins and masked tracks
      for (int s = 0; s < 2; s++) drive_set({mk_word(40, -72), mk_word(40, 64)}, 2'b11);
      for (int s = 0; s < 2; s++) drive_set({mk_word(40, 8), mk_word(40, 0)}, 2'b00);
      latency_check();
      check_out("s3");
      check("s3_zero", hist_out, 0);
      check("s3_cnt0", trk_cnt_out, 0);
      consume();

      // gapped input
      check("setcnt_0", set_cnt_out, 0);
      for (int s = 0; s < NS; s++) begin
         drive_set({mk_word(20, 0), mk_word(20, 0)}, 2'b11);
         check("setcnt_step", set_cnt_out, 128'(s + 1));
         if (s < NS - 1) @(negedge clk);
      end
      latency_check();
      check_out("s4");
      check("s4_bin8", hist_out, s1_hist);
      check("setcnt_clr", set_cnt_out, 0);
      consume();

      // backpressure: A held while B completes
      for (int s = 0; s < NS; s++) begin rand_set(words, tv); drive_set(words, tv); end
      check_out("s5a");
      for (int s = 0; s < NS; s++) begin rand_set(words, tv); drive_set(words, tv); end
      for (int k = 0; k < 6; k++) begin
         check("hold_rdy", rdy_out, 0);
         check("hold_vld", vld_out, 1);
         check("hold_hist", hist_out, exp_hist_q[0]);
         @(negedge clk);
      end
      consume();
      check("bp_merge_rdy", rdy_out, 0);
      @(negedge clk);
      check("bp_b_rdy", rdy_out, 1);
      check_out("s5b");

      // reset mid-event with B still on the output
      for (int s = 0; s < 2; s++) begin rand_set(words, tv); drive_set(words, tv); end
      do_reset();
      for (int s = 0; s < NS; s++) drive_set({mk_word(20, 0), mk_word(20, 0)}, 2'b11);
      latency_check();
      check_out("s6");
      check("s6_bin8", hist_out, s1_hist);
      consume();

      // random events with random gaps and sink stalls
      for (int e = 0; e < 6; e++) begin
         for (int s = 0; s < NS; s++) begin
            rand_set(words, tv);
            drive_set(words, tv);
            for (int g = $urandom_range(0, 2); g > 0; g--) @(negedge clk);
         end
         check_out("rnd");
         for (int g = $urandom_range(0, 3); g > 0; g--) @(negedge clk);
         consume();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/vertex_hist_accum.md
# vertex_hist_accum

Parametrised successor of the vertex-finding z0 histogrammer. Accepts a stream of track sets and builds one pT-weighted (or count-weighted) z0 histogram per event from per-lane saturating accumulators. It then merges the lanes into a flat histogram for the downstream peak finder. The output is double-buffered, so the next event accumulates while the previous histogram waits on back-pressure. Adds per-track valid masking, a count mode, a per-event track count and a saturation flag.

## Interface

- N_TRK, c_TRACKS_IN_SET: track lanes per input set
- N_SETS, c_SETS_IN_EVENT: sets per event
- N_BINS, c_HIST_BINS: histogram bins (even)
- BIN_W, c_HIST_BIN_WIDTH: bin width in bits (lane and output)
- Z0_SHIFT, 3: z0 LSBs dropped to form the bin index
- PT_MAX, c_PT_MAX: weight saturation value (pT/2 units)
- WEIGHT_MODE, 0: 0 = weight min(pT/2, PT_MAX); 1 = weight 1
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- track_set_in  in  N_TRK x c_TRACK_WORD_WIDTH  track words, decoded with tw2tw_struct
- trk_vld_in  in  N_TRK  per-lane track valid
- vld_in  in  1  set valid
- rdy_out  out  1  ready to accept a set
- hist_out  out  N_BINS*BIN_W  flat histogram; bin i at [i*BIN_W +: BIN_W]
- vld_out  out  1  histogram valid
- rdy_in  in  1  sink ready
- trk_cnt_out  out  16  tracks counted in the event on hist_out, saturating at 65535
- sat_out  out  1  some bin of hist_out saturated (lane or merge)
- set_cnt_out  out  $clog2(N_SETS+1)  sets accepted in the current event

## Operation

- A set is accepted when vld_in && rdy_out. Gaps in vld_in are allowed and have no effect.
- Per lane: bin = signed(z0[MSB:Z0_SHIFT]) + N_BINS/2. The track is counted iff trk_vld_in[lane] is set and 0 <= bin <= N_BINS-1.
- The weight is added to the lane accumulator bin. The result clamps at 2^BIN_W-1, and a clamp sets the event sat flag.
- FSM states:
  - ACC: rdy_out = 1. Moves to DRAIN when the N_SETS-th set is accepted.
  - DRAIN: 2 cycles, rdy_out = 0, flushes the pipeline. Then moves to MERGE if the output slot is free (vld_out = 0, or vld_out && rdy_in this cycle). Otherwise moves to WAIT.
  - WAIT: rdy_out = 0. Moves to MERGE when the output slot frees.
  - MERGE: 1 cycle. Each output bin is the sum of all lanes, computed in BIN_W+$clog2(N_TRK) bits, then clamped to 2^BIN_W-1. The clamp sets sat. The merge loads hist_out, trk_cnt_out and sat_out, sets vld_out, clears the accumulators, set_cnt and the event counters, then returns to ACC.
- The output handshake is independent of the FSM. vld_out falls on the cycle after vld_out && rdy_in. hist_out is held stable while vld_out = 1.
- Reset at any point:
  - Clears all accumulators, counters and output registers.
  - Drops any in-flight event.
  - The FSM enters ACC.

## Timing

- Reset values: rdy_out 0, vld_out 0, hist_out 0, trk_cnt_out 0, sat_out 0, set_cnt_out 0. rdy_out rises in the first cycle after rst is released.
- Lane pipeline is 2 stages: register the decoded words, then update the accumulator.
- Last set accepted in cycle c:
  - rdy_out is 0 in cycles c+1 to c+3.
  - MERGE happens in cycle c+3.
  - vld_out = 1 from c+4.
  - rdy_out = 1 from c+4.
- Peak throughput is one event per N_SETS+3 cycles.
- set_cnt_out increments the cycle after each accept.

## Structure

- global_pkg holds t_track_word_struct, tw2tw_struct, c_TRACK_WORD_WIDTH and the default constants.
- global_pkg also gains c_HIST_Z0_SHIFT and c_HIST_WEIGHT_MODE.
- Sub-module vertex_hist_lane, instantiated N_TRK times, contains:
  - bin/weight decode
  - accumulator register
  - clamp logic
  - clear input and sat output
- The top level holds the FSM, merge adder tree, output register and counters.

## Test plan

All scenarios use N_TRK=2, N_BINS=16, BIN_W=8, N_SETS=4, Z0_SHIFT=3, PT_MAX=63, WEIGHT_MODE=0.

- 4 sets, all tracks valid, z0=0, pT=20 -> bin 8 = 80, other bins 0, trk_cnt_out=8, sat_out=0, vld_out rises 4 cycles after the last accept.
- 4 sets, z0=0, pT=254 -> weight 63, sum 504 clamped -> bin 8 = 255, sat_out=1.
- Lane 0 z0=+64 (bin 16) and lane 1 z0=-72 (bin -1), or trk_vld_in=0 -> hist_out all 0, trk_cnt_out=0.
- vld_in toggled 1-0-1-0 -> result identical to the first scenario, and set_cnt_out steps 0..4.
- rdy_in=0 holding event A while event B completes -> rdy_out stays 0 and hist_out holds A. Then rdy_in=1 for one cycle -> B appears 1 cycle later and rdy_out returns to 1.
- rst pulsed after 2 sets -> all outputs 0. A following clean event gives the first scenario's result, with no carry-over.
